// File: rtl/plot_capture_pkg.sv
// Shared types, screen geometry and helpers for the plot_capture block.
package plot_capture_pkg;

  localparam logic [7:0] SCREEN_W  = 8'd160;
  localparam logic [6:0] SCREEN_H  = 7'd120;
  localparam int         FB_DEPTH  = 19200;
  localparam logic [14:0] LAST_ADDR = 15'd19199;
  localparam logic [14:0] CNT_MAX   = 15'h7FFF;

  typedef logic [2:0]  colour_t;
  typedef logic [14:0] pix_addr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } cap_state_t;

  typedef struct packed {
`ifdef PLOT_CAPTURE_BBOX_EN
    logic [7:0] x;
    logic [6:0] y;
`endif
    pix_addr_t  addr;
    colour_t    colour;
  } plot_entry_t;

  // y*160 + x without a multiplier.
  function automatic pix_addr_t pix_addr(input logic [7:0] x, input logic [6:0] y);
    pix_addr_t yw;
    yw = {8'd0, y};
    return (yw << 7) + (yw << 5) + {7'd0, x};
  endfunction

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

  function automatic logic [14:0] sat_inc(input logic [14:0] c);
    return (c == CNT_MAX) ? c : c + 15'd1;
  endfunction

endpackage

// File: rtl/plot_capture_if.sv
// Pixel-plot stream, read port and status bundle for plot_capture.
// PLOT_CAPTURE_BBOX_EN adds the bounding-box outputs.
interface plot_capture_if;
  import plot_capture_pkg::*;

  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  colour_t     vga_colour;
  logic        vga_plot;
  logic        clear;
  logic        busy;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  colour_t     rd_colour;
  logic [14:0] plot_count;
  logic [14:0] reject_count;
  logic        overflow;
`ifdef PLOT_CAPTURE_BBOX_EN
  logic [7:0]  bbox_xmin;
  logic [7:0]  bbox_xmax;
  logic [6:0]  bbox_ymin;
  logic [6:0]  bbox_ymax;
`endif

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, clear, rd_req, rd_x, rd_y,
`ifdef PLOT_CAPTURE_BBOX_EN
    input  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
`endif
    input  busy, rd_valid, rd_colour, plot_count, reject_count, overflow
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, clear, rd_req, rd_x, rd_y,
`ifdef PLOT_CAPTURE_BBOX_EN
    output bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
`endif
    output busy, rd_valid, rd_colour, plot_count, reject_count, overflow
  );

endinterface

// File: rtl/plot_fifo.sv
// Plot-request FIFO; push while full is legal only together with a pop.
module plot_fifo
  import plot_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  plot_entry_t din,
  output plot_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  plot_entry_t     entries_q [DEPTH];
  plot_entry_t     entries_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        entries_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = entries_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/plot_capture.sv
// Captures the VGA plot stream into a 160x120x3 shadow framebuffer with a read port.
// PLOT_CAPTURE_BBOX_EN adds bounding-box tracking of written pixels.
module plot_capture
  import plot_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  plot_capture_if.slave bus
);

  cap_state_t  state_q, state_d;
  pix_addr_t   wipe_q, wipe_d;
  logic        busy_q, busy_d;
  logic [14:0] plot_cnt_q, plot_cnt_d;
  logic [14:0] rej_cnt_q, rej_cnt_d;
  logic        ovf_q, ovf_d;
  logic        rd_p1_q, rd_p1_d;
  logic        rd_off_p1_q, rd_off_p1_d;
  logic        rd_p2_q, rd_p2_d;
  colour_t     rd_col_p2_q, rd_col_p2_d;
  logic        rd_valid_q, rd_valid_d;
  colour_t     rd_colour_q, rd_colour_d;

  logic        ram_we, ram_re;
  pix_addr_t   ram_addr;
  colour_t     ram_wdata;
  colour_t     ram_rdata_q;
  colour_t     fb_q [FB_DEPTH];

  logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  plot_entry_t fifo_din, fifo_dout;
  logic        clear_now, plot_on, rd_on;

  assign plot_on = on_screen(bus.vga_x, bus.vga_y);
  assign rd_on   = on_screen(bus.rd_x, bus.rd_y);

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Address is resolved at enqueue so the drain path is a plain write.
  always_comb begin
    fifo_din        = '0;
    fifo_din.addr   = pix_addr(bus.vga_x, bus.vga_y);
    fifo_din.colour = bus.vga_colour;
`ifdef PLOT_CAPTURE_BBOX_EN
    fifo_din.x      = bus.vga_x;
    fifo_din.y      = bus.vga_y;
`endif
  end

  // Single-port framebuffer: exactly one write or one read per cycle.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      fb_q[ram_addr] <= ram_wdata;
    end else if (ram_re) begin
      ram_rdata_q <= fb_q[ram_addr];
    end
  end

  always_comb begin
    state_d     = state_q;
    wipe_d      = wipe_q;
    plot_cnt_d  = plot_cnt_q;
    rej_cnt_d   = rej_cnt_q;
    ovf_d       = ovf_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    rd_p1_d     = 1'b0;
    rd_off_p1_d = 1'b0;
    clear_now   = 1'b0;

    case (state_q)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = wipe_q;
        if (wipe_q == LAST_ADDR) begin
          state_d = RUN;
          wipe_d  = '0;
        end else begin
          wipe_d = wipe_q + 15'd1;
        end
      end
      RUN: begin
        if (bus.clear) begin
          clear_now  = 1'b1;
          fifo_flush = 1'b1;
          state_d    = CLEAR;
          wipe_d     = '0;
        end else if (bus.rd_req) begin
          // Off-screen reads use a safe address and return 0 at the output.
          ram_re      = 1'b1;
          ram_addr    = rd_on ? pix_addr(bus.rd_x, bus.rd_y) : '0;
          rd_p1_d     = 1'b1;
          rd_off_p1_d = ~rd_on;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = fifo_dout.addr;
          ram_wdata  = fifo_dout.colour;
          plot_cnt_d = sat_inc(plot_cnt_q);
        end else begin
          fifo_pop = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        wipe_d  = '0;
      end
    endcase

    // A clear pulse wins over the plot arriving in the same cycle.
    if (clear_now) begin
      plot_cnt_d = '0;
      rej_cnt_d  = '0;
      ovf_d      = 1'b0;
    end else if (bus.vga_plot) begin
      if (!plot_on) begin
        rej_cnt_d = sat_inc(rej_cnt_q);
      end else if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      fifo_push = 1'b0;
    end

    busy_d      = (state_d == CLEAR);
    rd_p2_d     = rd_p1_q;
    rd_col_p2_d = (rd_p1_q && !rd_off_p1_q) ? ram_rdata_q : 3'd0;
    rd_valid_d  = rd_p2_q;
    rd_colour_d = rd_col_p2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      wipe_q      <= '0;
      busy_q      <= 1'b1;
      plot_cnt_q  <= '0;
      rej_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      rd_p1_q     <= 1'b0;
      rd_off_p1_q <= 1'b0;
      rd_p2_q     <= 1'b0;
      rd_col_p2_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_colour_q <= '0;
    end else begin
      state_q     <= state_d;
      wipe_q      <= wipe_d;
      busy_q      <= busy_d;
      plot_cnt_q  <= plot_cnt_d;
      rej_cnt_q   <= rej_cnt_d;
      ovf_q       <= ovf_d;
      rd_p1_q     <= rd_p1_d;
      rd_off_p1_q <= rd_off_p1_d;
      rd_p2_q     <= rd_p2_d;
      rd_col_p2_q <= rd_col_p2_d;
      rd_valid_q  <= rd_valid_d;
      rd_colour_q <= rd_colour_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_colour    = rd_colour_q;
  assign bus.plot_count   = plot_cnt_q;
  assign bus.reject_count = rej_cnt_q;
  assign bus.overflow     = ovf_q;

`ifdef PLOT_CAPTURE_BBOX_EN
  logic [7:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [6:0] ymin_q, ymin_d, ymax_q, ymax_d;

  // Every pop is a framebuffer write, so it drives the extremes.
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (clear_now) begin
      xmin_d = 8'hFF;
      xmax_d = 8'h00;
      ymin_d = 7'h7F;
      ymax_d = 7'h00;
    end else if (fifo_pop) begin
      xmin_d = (fifo_dout.x < xmin_q) ? fifo_dout.x : xmin_q;
      xmax_d = (fifo_dout.x > xmax_q) ? fifo_dout.x : xmax_q;
      ymin_d = (fifo_dout.y < ymin_q) ? fifo_dout.y : ymin_q;
      ymax_d = (fifo_dout.y > ymax_q) ? fifo_dout.y : ymax_q;
    end else begin
      xmin_d = xmin_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmin_q <= 8'hFF;
      xmax_q <= 8'h00;
      ymin_q <= 7'h7F;
      ymax_q <= 7'h00;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  assign bus.bbox_xmin = xmin_q;
  assign bus.bbox_xmax = xmax_q;
  assign bus.bbox_ymin = ymin_q;
  assign bus.bbox_ymax = ymax_q;
`endif

endmodule
